// File: rtl/usb_pkg.sv
// Shared types for the USB receive front end: line symbols, receiver states, the SYNC pattern
// and the pin-pair decoder.
package usb_pkg;

    typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0, LINE_SE1} line_t;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_SYNC, ST_RECV, ST_EOP1, ST_EOP2} rx_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_MAX_BITS       = 128;

    // Oldest symbol first.
    localparam line_t SYNC_PATTERN [8] = '{LINE_K, LINE_J, LINE_K, LINE_J,
                                           LINE_K, LINE_J, LINE_K, LINE_K};

    function automatic line_t decode_line(input logic dp, input logic dm);
        line_t l;
        case ({dp, dm})
            2'b10:   l = LINE_J;
            2'b01:   l = LINE_K;
            2'b00:   l = LINE_SE0;
            default: l = LINE_SE1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/usb_sync_detect.sv
// SYNC hunter: keeps the 7 previous line symbols and flags when they plus the live symbol
// form KJKJKJKK. Clear (and reset) refill the history with J so a match needs 8 fresh symbols.
module usb_sync_detect
    import usb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_b,
    input  logic  shift,
    input  logic  clear,
    input  line_t sym,
    output logic  match
);

    line_t hist [7];

    always_ff @(posedge clk) begin
        if (rst_b || clear) begin
            for (int i = 0; i < 7; i++) hist[i] <= LINE_J;
        end else if (shift) begin
            for (int i = 0; i < 6; i++) hist[i] <= hist[i+1];
            hist[6] <= sym;
        end
    end

    always_comb begin
        match = shift;
        for (int i = 0; i < 7; i++) begin
            if (hist[i] != SYNC_PATTERN[i]) match = 1'b0;
        end
        if (sym != SYNC_PATTERN[7]) match = 1'b0;
    end

endmodule

// File: rtl/usb_line_receiver.sv
// USB receive front end: registers D+/D-, hunts SYNC, streams raw J/K levels, checks EOP.
// Pin sample at cycle n reaches the outputs at n+2; re low aborts any packet silently.
module usb_line_receiver
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_BITS       = DEF_MAX_BITS
) (
    input  logic clk,
    input  logic rst_b,
    input  logic re,
    input  logic dp_r,
    input  logic dm_r,
    output logic bit_out,
    output logic bit_valid,
    output logic pkt_start,
    output logic pkt_done,
    output logic timeout,
    output logic line_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(MAX_BITS + 1);

    rx_state_t      state, state_d;
    line_t          sym_q;
    logic           re_q;
    logic [TW-1:0]  timer, timer_d;
    logic [BW-1:0]  bitcnt, bitcnt_d;
    logic           sh_en, sh_clr, match;
    logic           bit_out_d, bit_valid_d, start_d, done_d, timeout_d, err_d;

    wire re_rise = re & ~re_q;

    // re_q follows re even through reset so a reset with re held high cannot open a window.
    always_ff @(posedge clk) re_q <= re;

    usb_sync_detect u_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .shift (sh_en),
        .clear (sh_clr),
        .sym   (sym_q),
        .match (match)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            sym_q     <= LINE_J;
            state     <= ST_IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            timeout   <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            sym_q     <= decode_line(dp_r, dm_r);
            state     <= state_d;
            timer     <= timer_d;
            bitcnt    <= bitcnt_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            pkt_start <= start_d;
            pkt_done  <= done_d;
            timeout   <= timeout_d;
            line_err  <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        bitcnt_d    = bitcnt;
        sh_en       = 1'b0;
        sh_clr      = 1'b0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        err_d       = 1'b0;

        if (state != ST_IDLE && !re) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (re_rise) begin
                        state_d = ST_WAIT_SYNC;
                        timer_d = '0;
                        sh_clr  = 1'b1;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sym_q == LINE_SE0 || sym_q == LINE_SE1) sh_clr = 1'b1;
                    else                                        sh_en  = 1'b1;
                    // A match on the final timer cycle still wins over the timeout.
                    if (match) begin
                        state_d  = ST_RECV;
                        start_d  = 1'b1;
                        bitcnt_d = '0;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
                ST_RECV: begin
                    case (sym_q)
                        LINE_J, LINE_K: begin
                            if (bitcnt == BW'(MAX_BITS)) begin
                                state_d = ST_IDLE;
                                err_d   = 1'b1;
                            end else begin
                                bit_valid_d = 1'b1;
                                bit_out_d   = (sym_q == LINE_J);
                                bitcnt_d    = bitcnt + BW'(1);
                            end
                        end
                        LINE_SE0: state_d = ST_EOP1;
                        default: begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                ST_EOP1: begin
                    if (sym_q == LINE_SE0) begin
                        state_d = ST_EOP2;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_EOP2: begin
                    state_d = ST_IDLE;
                    if (sym_q == LINE_J) done_d = 1'b1;
                    else                 err_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_line_receiver.sv
// Scoreboarded bench for usb_line_receiver: each receive window's expected events are derived
// by parsing the symbol list, then a monitor matches every DUT output against that queue.
module tb_usb_line_receiver;

    localparam int TMO  = 255;
    localparam int MAXB = 128;
    // Symbol codes used by the bench: 0=J 1=K 2=SE0 3=SE1
    localparam int SJ = 0, SK = 1, S0 = 2, S1 = 3;

    typedef struct {
        int kind;   // 0 bit, 1 start, 2 done, 3 timeout, 4 line_err
        int bitv;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_b, re, dp_r, dm_r;
    logic bit_out, bit_valid, pkt_start, pkt_done, timeout, line_err;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    ev_t  exp_q[$];
    int   sq[$];
    int   sync_pat[8] = '{SK, SJ, SK, SJ, SK, SJ, SK, SK};

    usb_line_receiver #(.TIMEOUT_CYCLES(TMO), .MAX_BITS(MAXB)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .re        (re),
        .dp_r      (dp_r),
        .dm_r      (dm_r),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .pkt_start (pkt_start),
        .pkt_done  (pkt_done),
        .timeout   (timeout),
        .line_err  (line_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "bit";
            1: return "pkt_start";
            2: return "pkt_done";
            3: return "timeout";
            4: return "line_err";
            default: return "none";
        endcase
    endfunction

    task automatic set_pins(input int c);
        case (c)
            SJ: begin dp_r = 1'b1; dm_r = 1'b0; end
            SK: begin dp_r = 1'b0; dm_r = 1'b1; end
            S0: begin dp_r = 1'b0; dm_r = 1'b0; end
            default: begin dp_r = 1'b1; dm_r = 1'b1; end
        endcase
    endtask

    task automatic push_ev(input int kind, input int bitv, input int c);
        ev_t e;
        e.kind = kind; e.bitv = bitv; e.cyc = c;
        exp_q.push_back(e);
    endtask

    function automatic bit is_sync_at(input int last);
        for (int j = 0; j < 8; j++)
            if (sq[last - 7 + j] != sync_pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Parse the first p symbols of sq as a packet; symbol i drives the outputs at cycle s+i+1.
    task automatic model(input int p, input int s);
        int found = -1;
        int nb = 0;
        int i;
        for (int k = 7; k < p && k < TMO; k++) begin
            if (is_sync_at(k)) begin found = k; break; end
        end
        if (found < 0) begin
            if (p >= TMO) push_ev(3, 0, s + TMO);
            return;
        end
        push_ev(1, 0, s + found + 1);
        i = found + 1;
        while (i < p) begin
            if (sq[i] == SJ || sq[i] == SK) begin
                if (nb == MAXB) begin push_ev(4, 0, s + i + 1); return; end
                push_ev(0, (sq[i] == SJ) ? 1 : 0, s + i + 1);
                nb++;
                i++;
            end else if (sq[i] == S1) begin
                push_ev(4, 0, s + i + 1);
                return;
            end else begin
                if (i + 1 >= p) return;
                if (sq[i+1] != S0) begin push_ev(4, 0, s + i + 2); return; end
                if (i + 2 >= p) return;
                push_ev((sq[i+2] == SJ) ? 2 : 4, 0, s + i + 3);
                return;
            end
        end
    endtask

    // Drive sq with re high for n_re cycles; optional one-cycle reset at relative cycle rst_at.
    task automatic run_window(input int n_re, input int rst_at);
        int s = cyc + 1;
        int p = ((rst_at >= 0 && rst_at < n_re) ? rst_at : n_re) - 1;
        while (sq.size() < n_re) sq.push_back(SJ);
        model(p, s);
        for (int k = 0; k < n_re + 4; k++) begin
            re    = (k < n_re);
            rst_b = (k == rst_at);
            set_pins((k < n_re) ? sq[k] : SJ);
            @(negedge clk);
            if (k == rst_at) begin
                compared++;
                if ({bit_out, bit_valid, pkt_start, pkt_done, timeout, line_err} != 6'b0) begin
                    mismatched++;
                    $display("FAIL reset_mid_packet: outputs=%b required 000000",
                             {bit_out, bit_valid, pkt_start, pkt_done, timeout, line_err});
                end
            end
        end
        rst_b = 1'b0;
        sq.delete();
    endtask

    task automatic add_sync();
        for (int j = 0; j < 8; j++) sq.push_back(sync_pat[j]);
    endtask

    always @(negedge clk) begin
        int nf, kind;
        ev_t e;
        nf = int'(bit_valid) + int'(pkt_start) + int'(pkt_done) + int'(timeout) + int'(line_err);
        if (nf != 0) begin
            compared++;
            if (nf != 1) begin
                mismatched++;
                $display("FAIL onehot: cycle %0d has %0d flags set, required 1", cyc, nf);
            end
            kind = bit_valid ? 0 : pkt_start ? 1 : pkt_done ? 2 : timeout ? 3 : 4;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected: %s at cycle %0d, required nothing", kname(kind), cyc);
            end else begin
                e = exp_q.pop_front();
                compared++;
                if (kind != e.kind || cyc != e.cyc || (kind == 0 && int'(bit_out) != e.bitv)) begin
                    mismatched++;
                    $display("FAIL event: got %s bit=%0d cycle %0d, required %s bit=%0d cycle %0d",
                             kname(kind), bit_out, cyc, kname(e.kind), e.bitv, e.cyc);
                end
            end
        end
    end

    initial begin
        int n, nbits, ending;
        rst_b = 1'b1; re = 1'b0; set_pins(SJ);
        repeat (3) @(negedge clk);
        compared++;
        if ({bit_out, bit_valid, pkt_start, pkt_done, timeout, line_err} != 6'b0) begin
            mismatched++;
            $display("FAIL reset_state: outputs=%b required 000000",
                     {bit_out, bit_valid, pkt_start, pkt_done, timeout, line_err});
        end
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Basic packet: idle J, SYNC, K J J K, EOP.
        sq = '{SJ, SJ, SJ};
        add_sync();
        sq.push_back(SK); sq.push_back(SJ); sq.push_back(SJ); sq.push_back(SK);
        sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ);
        run_window(sq.size() + 3, -1);

        // SYNC timeout, then re held high with no further pulses.
        run_window(TMO + 50, -1);

        // Bad EOP.
        add_sync();
        sq.push_back(SK); sq.push_back(SJ); sq.push_back(S0); sq.push_back(SK);
        run_window(sq.size() + 3, -1);

        // Babble: 129 alternating bits.
        add_sync();
        for (int j = 0; j < MAXB + 1; j++) sq.push_back((j % 2 == 0) ? SJ : SK);
        run_window(sq.size() + 3, -1);

        // re drop after 5 bits, then a full packet in a fresh window.
        add_sync();
        for (int j = 0; j < 10; j++) sq.push_back((j % 3 == 0) ? SK : SJ);
        run_window(8 + 5 + 1, -1);
        add_sync();
        sq.push_back(SJ); sq.push_back(SK);
        sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ);
        run_window(sq.size() + 2, -1);

        // Empty packet.
        add_sync();
        sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ);
        run_window(sq.size() + 2, -1);

        // Reset mid-RECV; the trailing EOP must be ignored.
        add_sync();
        for (int j = 0; j < 4; j++) sq.push_back(SK);
        sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ);
        run_window(sq.size() + 3, 8 + 4 + 1);

        // Randomised windows: noisy preamble, optional SYNC, random payload and ending.
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 20);
            for (int j = 0; j < n; j++)
                sq.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 3))
                                                         : int'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) != 0) add_sync();
            nbits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAXB - 3, MAXB + 4))
                                                : int'($urandom_range(0, 30));
            for (int j = 0; j < nbits; j++) sq.push_back(int'($urandom_range(0, 1)));
            ending = $urandom_range(0, 5);
            case (ending)
                0, 1, 2: begin sq.push_back(S0); sq.push_back(S0); sq.push_back(SJ); end
                3: begin sq.push_back(S0); sq.push_back(int'($urandom_range(0, 3))); end
                4: begin sq.push_back(S0); sq.push_back(S0); sq.push_back(int'($urandom_range(1, 3))); end
                default: sq.push_back(S1);
            endcase
            run_window(sq.size() + 1 - int'($urandom_range(0, 3)) + int'($urandom_range(0, 3)), -1);
        end

        repeat (4) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_events: %0d expected events never appeared, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
